// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8-bit LSB-first UART transmitter with internal baud timing
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_MAX = 3'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
            $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             ready_q;
    logic             wrap;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    assign wrap       = (cnt_q == CNT_MAX);
    assign tx_o       = tx_q;
    assign tx_ready_o = ready_q;

    // idx_q counts data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    if (tx_start_i) begin
                        shift_q  <= tx_data_i;
`ifdef UART_TX_PARITY_EN
                        parity_q <= (^tx_data_i) ^ 1'(PARITY_ODD);
`endif
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (wrap) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (wrap) begin
                        cnt_q   <= '0;
                        shift_q <= shift_q >> 1;
                        if (idx_q == 3'd7) begin
                            idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (wrap) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        if (idx_q == STOP_MAX) begin
                            idx_q   <= '0;
                            ready_q <= 1'b1;
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

endmodule
